// File: rtl/sata_prim_pkg.sv
// -----------------------------------------------------------------------------
// sata_prim_pkg
// Shared SATA link-layer definitions used by the device responder and by the
// host model: primitive dword constants (all sent with charisk=1), the link
// state enum, and small helpers for state classification and the
// per-state transmit primitive.
// -----------------------------------------------------------------------------
package sata_prim_pkg;

    localparam logic [31:0] PRIM_ALIGN = 32'h7B4A_4ABC;
    localparam logic [31:0] PRIM_SYNC  = 32'hB5B5_957C;
    localparam logic [31:0] PRIM_X_RDY = 32'h5757_B57C;
    localparam logic [31:0] PRIM_R_RDY = 32'h4A4A_957C;
    localparam logic [31:0] PRIM_R_IP  = 32'h5555_B57C;
    localparam logic [31:0] PRIM_R_OK  = 32'h3535_B57C;
    localparam logic [31:0] PRIM_SOF   = 32'h3737_B57C;
    localparam logic [31:0] PRIM_EOF   = 32'hD5D5_B57C;
    localparam logic [31:0] PRIM_WTRM  = 32'h5858_B57C;
    localparam logic [31:0] PRIM_HOLD  = 32'hD5D5_AA7C;
    localparam logic [31:0] PRIM_HOLDA = 32'h9595_AA7C;
    localparam logic [31:0] PRIM_CONT  = 32'h9999_AA7C;

    typedef enum logic [2:0] {
        LINK_DOWN  = 3'd0,
        SEND_ALIGN = 3'd1,
        IDLE       = 3'd2,
        RCV_RDY    = 3'd3,
        RCV_DATA   = 3'd4,
        RCV_EOF    = 3'd5,
        GOOD_END   = 3'd6
    } link_state_e;

    // The link is "ready" once the ALIGN handshake has completed; only then
    // do periodic ALIGN insertion and the primitive filter apply.
    function automatic logic link_ready(link_state_e s);
        return (s != LINK_DOWN) && (s != SEND_ALIGN);
    endfunction

    // Primitive transmitted while sitting in a given state.
    function automatic logic [31:0] state_response(link_state_e s, logic rx_hold);
        unique case (s)
            IDLE:     return PRIM_SYNC;
            RCV_RDY:  return PRIM_R_RDY;
            RCV_DATA: return rx_hold ? PRIM_HOLDA : PRIM_R_IP;
            RCV_EOF:  return PRIM_R_IP;
            GOOD_END: return PRIM_R_OK;
            default:  return PRIM_ALIGN;
        endcase
    endfunction

endpackage

// File: rtl/sata_dev_link_fsm.sv
// -----------------------------------------------------------------------------
// sata_dev_link_fsm
// Device-side SATA link-layer responder (75 MHz dword domain). After the PHY
// reports link up it completes the ALIGN->SYNC handshake, then answers every
// host frame with SYNC/R_RDY/R_IP/HOLDA/R_OK. Once ready, two ALIGNs are
// inserted after every ALIGN_PERIOD transmitted dwords. It also sequences the
// PHY reset from the clock-manager lock.
//
// Ports:
//   dev_clk_75M     in   clock, rising edge
//   rst_n           in   synchronous active-low reset
//   sata_dcm_lock   in   clock-manager lock, 0 holds the PHY in reset
//   link_up         in   PHY OOB complete
//   dev_rx_data     in   received dword (byte0 first)
//   dev_rx_charisk  in   1 = received dword is a primitive
//   dev_tx_data     out  dword to transmit (registered)
//   dev_tx_charisk  out  1 = transmitted dword is a primitive
//   phy_rst_n       out  active-low PHY reset (registered)
// -----------------------------------------------------------------------------
module sata_dev_link_fsm
    import sata_prim_pkg::*;
#(
    parameter int ALIGN_PERIOD = 256,
    parameter int PHY_RST_HOLD = 16
) (
    input  logic        dev_clk_75M,
    input  logic        rst_n,
    input  logic        sata_dcm_lock,
    input  logic        link_up,
    input  logic [31:0] dev_rx_data,
    input  logic        dev_rx_charisk,
    output logic [31:0] dev_tx_data,
    output logic        dev_tx_charisk,
    output logic        phy_rst_n
);

    localparam int CNT_W  = (ALIGN_PERIOD > 1) ? $clog2(ALIGN_PERIOD) : 1;
    localparam int HOLD_W = (PHY_RST_HOLD > 1) ? $clog2(PHY_RST_HOLD) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(ALIGN_PERIOD - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(PHY_RST_HOLD - 1);

    link_state_e        state_q, state_d;
    logic [31:0]        last_prim_q, last_prim_d;
    logic               cont_q, cont_d;
    logic [CNT_W-1:0]   align_cnt_q, align_cnt_d;
    logic [1:0]         align_pend_q, align_pend_d;
    logic [31:0]        tx_data_q, tx_data_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               phy_rst_n_q, phy_rst_n_d;

    // Receive classification. A "fresh" primitive is any primitive except
    // ALIGN and CONT; those two never count as a new primitive.
    logic rx_align, rx_cont, rx_fresh, rx_hold;

    assign rx_align = dev_rx_charisk && (dev_rx_data == PRIM_ALIGN);
    assign rx_cont  = dev_rx_charisk && (dev_rx_data == PRIM_CONT);
    assign rx_fresh = dev_rx_charisk && !rx_align && !rx_cont;

    // Whether the primitive currently in effect is HOLD. Ignored dwords
    // (ALIGN, CONT, data after CONT) keep the last primitive in force; a raw
    // data dword with no CONT pending means no primitive is in force.
    always_comb begin
        if (rx_fresh) begin
            rx_hold = (dev_rx_data == PRIM_HOLD);
        end else if (!dev_rx_charisk && !cont_q) begin
            rx_hold = 1'b0;
        end else begin
            rx_hold = (last_prim_q == PRIM_HOLD);
        end
    end

    // Next-state logic. Transitions inside a frame react only to fresh
    // primitives, so repeated-by-CONT or ALIGN-masked dwords cannot re-fire.
    // NOTE: every signal assigned in this block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        last_prim_d = last_prim_q;
        cont_d      = cont_q;

        if (rx_cont) begin
            cont_d = 1'b1;
        end else if (rx_fresh) begin
            cont_d      = 1'b0;
            last_prim_d = dev_rx_data;
        end

        if (!link_up) begin
            state_d = LINK_DOWN;
        end else begin
            unique case (state_q)
                LINK_DOWN:  state_d = SEND_ALIGN;
                SEND_ALIGN: if (rx_align) state_d = IDLE;
                IDLE:       if (rx_fresh && dev_rx_data == PRIM_X_RDY) state_d = RCV_RDY;
                RCV_RDY: begin
                    if (rx_fresh && dev_rx_data == PRIM_SOF)       state_d = RCV_DATA;
                    else if (rx_fresh && dev_rx_data == PRIM_SYNC) state_d = IDLE;
                end
                RCV_DATA: begin
                    if (rx_fresh && dev_rx_data == PRIM_EOF)       state_d = RCV_EOF;
                    else if (rx_fresh && dev_rx_data == PRIM_SYNC) state_d = IDLE;
                end
                RCV_EOF:    if (rx_fresh && dev_rx_data == PRIM_WTRM) state_d = GOOD_END;
                GOOD_END:   if (rx_fresh && dev_rx_data == PRIM_SYNC) state_d = IDLE;
                default:    state_d = LINK_DOWN;
            endcase
        end

        // Filter history starts clean each time the link becomes ready.
        if (!link_ready(state_d)) begin
            last_prim_d = PRIM_SYNC;
            cont_d      = 1'b0;
        end
    end

    // Transmit scheduler: once ready, every ALIGN_PERIOD response dwords are
    // followed by two ALIGNs. The state machine keeps running underneath, so
    // the response shown after the pair reflects any transition made during it.
    always_comb begin
        align_cnt_d  = align_cnt_q;
        align_pend_d = align_pend_q;
        tx_data_d    = PRIM_ALIGN;

        if (!link_ready(state_d)) begin
            align_cnt_d  = '0;
            align_pend_d = 2'd0;
        end else if (align_pend_q != 2'd0) begin
            align_pend_d = align_pend_q - 2'd1;
        end else begin
            tx_data_d = state_response(state_d, rx_hold);
            if (align_cnt_q == CNT_LAST) begin
                align_cnt_d  = '0;
                align_pend_d = 2'd2;
            end else begin
                align_cnt_d = align_cnt_q + 1'b1;
            end
        end
    end

    // PHY reset release after PHY_RST_HOLD consecutive locked cycles; any
    // loss of lock re-asserts it on the next edge and restarts the count.
    always_comb begin
        hold_cnt_d  = hold_cnt_q;
        phy_rst_n_d = phy_rst_n_q;
        if (!sata_dcm_lock) begin
            hold_cnt_d  = '0;
            phy_rst_n_d = 1'b0;
        end else if (!phy_rst_n_q) begin
            if (hold_cnt_q == HOLD_LAST) begin
                phy_rst_n_d = 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge dev_clk_75M) begin
        if (!rst_n) begin
            state_q      <= LINK_DOWN;
            last_prim_q  <= PRIM_SYNC;
            cont_q       <= 1'b0;
            align_cnt_q  <= '0;
            align_pend_q <= 2'd0;
            tx_data_q    <= PRIM_ALIGN;
            hold_cnt_q   <= '0;
            phy_rst_n_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_prim_q  <= last_prim_d;
            cont_q       <= cont_d;
            align_cnt_q  <= align_cnt_d;
            align_pend_q <= align_pend_d;
            tx_data_q    <= tx_data_d;
            hold_cnt_q   <= hold_cnt_d;
            phy_rst_n_q  <= phy_rst_n_d;
        end
    end

    assign dev_tx_data    = tx_data_q;
    // The device only ever transmits primitives.
    assign dev_tx_charisk = 1'b1;
    assign phy_rst_n      = phy_rst_n_q;

endmodule

// File: tb/tb_sata_dev_link_fsm.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sata_dev_link_fsm
// Bench for the device link responder. A behavioural model tracks the link
// phase, the primitive in force and the position in the ready transmit
// stream (ALIGN pair at positions 256/257 of every 258) and predicts every
// transmitted dword and phy_rst_n.
// -----------------------------------------------------------------------------
module tb_sata_dev_link_fsm;
    import sata_prim_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lock = 1'b0;
    logic        link_up = 1'b0;
    logic [31:0] rx_d = PRIM_SYNC;
    logic        rx_k = 1'b1;
    logic [31:0] dev_tx_data;
    logic        dev_tx_charisk;
    logic        phy_rst_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sata_dev_link_fsm dut (
        .dev_clk_75M    (clk),
        .rst_n          (rst_n),
        .sata_dcm_lock  (lock),
        .link_up        (link_up),
        .dev_rx_data    (rx_d),
        .dev_rx_charisk (rx_k),
        .dev_tx_data    (dev_tx_data),
        .dev_tx_charisk (dev_tx_charisk),
        .phy_rst_n      (phy_rst_n)
    );

    // ---------------- reference model ----------------
    localparam int PH_DOWN = 0, PH_WAIT = 1, PH_IDLE = 2, PH_RDY = 3,
                   PH_DATA = 4, PH_EOF = 5, PH_GOOD = 6;
    localparam int STREAM_LEN = 256 + 2;

    int          m_ph;
    logic [31:0] m_last;
    bit          m_cont;
    int          m_n;
    int          m_lock_cycles;
    logic        m_phy;
    logic [31:0] m_tx;

    function automatic int m_next(int ph, logic [31:0] p);
        if (ph == PH_IDLE && p == PRIM_X_RDY) return PH_RDY;
        if (ph == PH_RDY  && p == PRIM_SOF)   return PH_DATA;
        if (ph == PH_RDY  && p == PRIM_SYNC)  return PH_IDLE;
        if (ph == PH_DATA && p == PRIM_EOF)   return PH_EOF;
        if (ph == PH_DATA && p == PRIM_SYNC)  return PH_IDLE;
        if (ph == PH_EOF  && p == PRIM_WTRM)  return PH_GOOD;
        if (ph == PH_GOOD && p == PRIM_SYNC)  return PH_IDLE;
        return ph;
    endfunction

    function automatic logic [31:0] m_resp(int ph, bit hold);
        case (ph)
            PH_IDLE: return PRIM_SYNC;
            PH_RDY:  return PRIM_R_RDY;
            PH_DATA: return hold ? PRIM_HOLDA : PRIM_R_IP;
            PH_EOF:  return PRIM_R_IP;
            PH_GOOD: return PRIM_R_OK;
            default: return PRIM_ALIGN;
        endcase
    endfunction

    task automatic model_edge();
        bit fresh, hold;
        if (!rst_n) begin
            m_ph = PH_DOWN; m_last = PRIM_SYNC; m_cont = 0; m_n = 0;
            m_lock_cycles = 0; m_phy = 1'b0; m_tx = PRIM_ALIGN;
            return;
        end
        if (!lock) begin
            m_lock_cycles = 0; m_phy = 1'b0;
        end else begin
            m_lock_cycles++;
            m_phy = (m_lock_cycles >= 16);
        end
        fresh = rx_k && rx_d != PRIM_ALIGN && rx_d != PRIM_CONT;
        if (fresh)              hold = (rx_d == PRIM_HOLD);
        else if (!rx_k && !m_cont) hold = 0;
        else                    hold = (m_last == PRIM_HOLD);
        if (rx_k && rx_d == PRIM_CONT) m_cont = 1;
        if (fresh) begin m_cont = 0; m_last = rx_d; end
        if (!link_up)            m_ph = PH_DOWN;
        else if (m_ph == PH_DOWN) m_ph = PH_WAIT;
        else if (m_ph == PH_WAIT) begin
            if (rx_k && rx_d == PRIM_ALIGN) m_ph = PH_IDLE;
        end else if (fresh)      m_ph = m_next(m_ph, rx_d);
        if (m_ph < PH_IDLE) begin
            m_last = PRIM_SYNC; m_cont = 0; m_n = 0; m_tx = PRIM_ALIGN;
        end else begin
            m_tx = ((m_n % STREAM_LEN) >= 256) ? PRIM_ALIGN : m_resp(m_ph, hold);
            m_n++;
        end
    endtask

    // Drive one rx dword on the falling edge, advance the model at the rising
    // edge, and leave the caller 1 ns after the edge to sample outputs.
    task automatic drive(input logic k, input logic [31:0] d);
        @(negedge clk);
        rx_k = k;
        rx_d = d;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [32:0] prim(logic [31:0] p);
        return {1'b1, p};
    endfunction

    function automatic logic [32:0] data_dw();
        return {1'b0, 32'($urandom)};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; lock = 1'b1; link_up = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, PRIM_SYNC);
            total++;
            if (dev_tx_data !== PRIM_ALIGN || dev_tx_charisk !== 1'b1 || phy_rst_n !== 1'b0) begin
                bad++;
                $display("FAIL reset cyc %0d: got tx=%h k=%b phy=%b, want tx=%h k=1 phy=0",
                         i, dev_tx_data, dev_tx_charisk, phy_rst_n, PRIM_ALIGN);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, PRIM_SYNC);
            total++;
            if (phy_rst_n !== (i >= 15) || dev_tx_data !== PRIM_ALIGN || dev_tx_charisk !== 1'b1) begin
                bad++;
                $display("FAIL phy_release cyc %0d: got phy=%b tx=%h k=%b, want phy=%b tx=%h k=1",
                         i + 1, phy_rst_n, dev_tx_data, dev_tx_charisk, (i >= 15), PRIM_ALIGN);
            end
        end
        lock = 1'b0;
        drive(1'b1, PRIM_SYNC);
        total++;
        if (phy_rst_n !== 1'b0 || phy_rst_n !== m_phy) begin
            bad++;
            $display("FAIL lock_drop: got phy=%b, want 0", phy_rst_n);
        end
        lock = 1'b1;
        for (int i = 0; i < 16; i++) drive(1'b1, PRIM_SYNC);
        total++;
        if (phy_rst_n !== 1'b1) begin
            bad++;
            $display("FAIL lock_regain: got phy=%b, want 1", phy_rst_n);
        end
    endtask

    task automatic test_handshake();
        int n_align = 0;
        int first_align = -1;
        link_up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, $urandom);
            total++;
            if (dev_tx_data !== m_tx || dev_tx_data !== PRIM_ALIGN) begin
                bad++;
                $display("FAIL handshake_wait cyc %0d: got tx=%h, want %h", i, dev_tx_data, PRIM_ALIGN);
            end
        end
        drive(1'b1, PRIM_ALIGN);
        total++;
        if (dev_tx_data !== PRIM_SYNC || dev_tx_data !== m_tx) begin
            bad++;
            $display("FAIL handshake_sync: got tx=%h, want %h", dev_tx_data, PRIM_SYNC);
        end
        for (int i = 1; i <= 300; i++) begin
            drive(1'b1, PRIM_SYNC);
            if (dev_tx_data === PRIM_ALIGN) begin
                n_align++;
                if (first_align < 0) first_align = i;
            end
            total++;
            if (dev_tx_data !== m_tx || dev_tx_charisk !== 1'b1) begin
                bad++;
                $display("FAIL idle_stream pos %0d: got tx=%h k=%b, want tx=%h k=1",
                         i, dev_tx_data, dev_tx_charisk, m_tx);
            end
        end
        total++;
        if (n_align != 2 || first_align != 256) begin
            bad++;
            $display("FAIL align_insert: got count=%0d first=%0d, want count=2 first=256",
                     n_align, first_align);
        end
    endtask

    task automatic test_good_frame();
        logic [32:0] seq[$];
        logic [31:0] want[$];
        seq  = '{prim(PRIM_X_RDY), prim(PRIM_SOF), data_dw(), data_dw(), data_dw(), data_dw(),
                 prim(PRIM_EOF), prim(PRIM_WTRM), prim(PRIM_SYNC)};
        want = '{PRIM_R_RDY, PRIM_R_IP, PRIM_R_IP, PRIM_R_IP, PRIM_R_IP, PRIM_R_IP,
                 PRIM_R_IP, PRIM_R_OK, PRIM_SYNC};
        foreach (seq[i]) begin
            drive(seq[i][32], seq[i][31:0]);
            total++;
            if (dev_tx_data !== m_tx || dev_tx_data !== want[i] || phy_rst_n !== m_phy) begin
                bad++;
                $display("FAIL good_frame step %0d: got tx=%h phy=%b, want tx=%h phy=%b",
                         i, dev_tx_data, phy_rst_n, want[i], m_phy);
            end
        end
    endtask

    task automatic test_hold_cont();
        logic [32:0] seq[$];
        logic [31:0] want[$];
        seq  = '{prim(PRIM_X_RDY), prim(PRIM_SOF), data_dw(), prim(PRIM_HOLD), prim(PRIM_CONT),
                 data_dw(), data_dw(), data_dw(), prim(PRIM_EOF), prim(PRIM_WTRM), prim(PRIM_SYNC)};
        want = '{PRIM_R_RDY, PRIM_R_IP, PRIM_R_IP, PRIM_HOLDA, PRIM_HOLDA,
                 PRIM_HOLDA, PRIM_HOLDA, PRIM_HOLDA, PRIM_R_IP, PRIM_R_OK, PRIM_SYNC};
        foreach (seq[i]) begin
            drive(seq[i][32], seq[i][31:0]);
            total++;
            if (dev_tx_data !== m_tx || dev_tx_data !== want[i]) begin
                bad++;
                $display("FAIL hold_cont step %0d: got tx=%h, want %h", i, dev_tx_data, want[i]);
            end
        end
    endtask

    task automatic test_abort();
        logic [32:0] seq[$];
        bit saw_rok = 0;
        seq = '{prim(PRIM_X_RDY), prim(PRIM_SOF), data_dw(), data_dw(),
                prim(PRIM_SYNC), prim(PRIM_SYNC)};
        foreach (seq[i]) begin
            drive(seq[i][32], seq[i][31:0]);
            if (dev_tx_data === PRIM_R_OK) saw_rok = 1;
            total++;
            if (dev_tx_data !== m_tx) begin
                bad++;
                $display("FAIL abort step %0d: got tx=%h, want %h", i, dev_tx_data, m_tx);
            end
        end
        total++;
        if (saw_rok || dev_tx_data !== PRIM_SYNC) begin
            bad++;
            $display("FAIL abort_end: got r_ok_seen=%0d tx=%h, want r_ok_seen=0 tx=%h",
                     saw_rok, dev_tx_data, PRIM_SYNC);
        end
    endtask

    task automatic test_link_loss();
        logic [32:0] seq[$];
        seq = '{prim(PRIM_X_RDY), prim(PRIM_SOF), data_dw(), prim(PRIM_EOF), prim(PRIM_WTRM)};
        foreach (seq[i]) drive(seq[i][32], seq[i][31:0]);
        total++;
        if (dev_tx_data !== PRIM_R_OK || dev_tx_data !== m_tx) begin
            bad++;
            $display("FAIL good_end_reached: got tx=%h, want %h", dev_tx_data, PRIM_R_OK);
        end
        link_up = 1'b0;
        drive(1'b1, PRIM_SYNC);
        total++;
        if (dev_tx_data !== PRIM_ALIGN || dev_tx_data !== m_tx) begin
            bad++;
            $display("FAIL link_loss: got tx=%h, want %h", dev_tx_data, PRIM_ALIGN);
        end
        // Back in LINK_DOWN, a single ALIGN only reaches SEND_ALIGN.
        link_up = 1'b1;
        drive(1'b1, PRIM_ALIGN);
        total++;
        if (dev_tx_data !== PRIM_ALIGN || dev_tx_data !== m_tx) begin
            bad++;
            $display("FAIL relink_wait: got tx=%h, want %h", dev_tx_data, PRIM_ALIGN);
        end
        drive(1'b1, PRIM_ALIGN);
        total++;
        if (dev_tx_data !== PRIM_SYNC || dev_tx_data !== m_tx) begin
            bad++;
            $display("FAIL relink_sync: got tx=%h, want %h", dev_tx_data, PRIM_SYNC);
        end
    endtask

    task automatic test_random_frames();
        logic [32:0] seq[$];
        for (int f = 0; f < 26; f++) begin
            seq.delete();
            repeat ($urandom_range(1, 3)) seq.push_back(prim(PRIM_SYNC));
            seq.push_back(prim(PRIM_X_RDY));
            seq.push_back(prim(PRIM_SOF));
            repeat ($urandom_range(1, 5)) seq.push_back(data_dw());
            if ($urandom_range(0, 1) == 1) begin
                seq.push_back(prim(PRIM_HOLD));
                if ($urandom_range(0, 1) == 1) seq.push_back(prim(PRIM_CONT));
                else seq.push_back(prim(PRIM_HOLD));
                repeat ($urandom_range(1, 3)) seq.push_back(data_dw());
                seq.push_back(prim(PRIM_R_IP));
                repeat ($urandom_range(0, 2)) seq.push_back(data_dw());
            end
            if ($urandom_range(0, 5) == 0) begin
                seq.push_back(prim(PRIM_SYNC));
            end else begin
                seq.push_back(prim(PRIM_EOF));
                seq.push_back(prim(PRIM_WTRM));
                seq.push_back(prim(PRIM_WTRM));
                seq.push_back(prim(PRIM_SYNC));
            end
            foreach (seq[i]) begin
                if ($urandom_range(0, 7) == 0) begin
                    drive(1'b1, PRIM_ALIGN);
                    total++;
                    if (dev_tx_data !== m_tx) begin
                        bad++;
                        $display("FAIL random_align f%0d: got tx=%h, want %h", f, dev_tx_data, m_tx);
                    end
                end
                drive(seq[i][32], seq[i][31:0]);
                total++;
                if (dev_tx_data !== m_tx || dev_tx_charisk !== 1'b1 || phy_rst_n !== m_phy) begin
                    bad++;
                    $display("FAIL random f%0d step %0d: got tx=%h k=%b phy=%b, want tx=%h k=1 phy=%b",
                             f, i, dev_tx_data, dev_tx_charisk, phy_rst_n, m_tx, m_phy);
                end
            end
        end
    endtask

    task automatic test_midframe_reset();
        drive(1'b1, PRIM_X_RDY);
        drive(1'b1, PRIM_SOF);
        drive(1'b0, $urandom);
        rst_n = 1'b0;
        drive(1'b0, $urandom);
        total++;
        if (dev_tx_data !== PRIM_ALIGN || dev_tx_charisk !== 1'b1 || phy_rst_n !== 1'b0) begin
            bad++;
            $display("FAIL midframe_reset: got tx=%h k=%b phy=%b, want tx=%h k=1 phy=0",
                     dev_tx_data, dev_tx_charisk, phy_rst_n, PRIM_ALIGN);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, PRIM_SOF);
            total++;
            if (dev_tx_data !== m_tx || phy_rst_n !== m_phy) begin
                bad++;
                $display("FAIL post_reset cyc %0d: got tx=%h phy=%b, want tx=%h phy=%b",
                         i, dev_tx_data, phy_rst_n, m_tx, m_phy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_good_frame();
        test_hold_cont();
        test_abort();
        test_link_loss();
        test_random_frames();
        test_midframe_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
